trap_sequencer: RTL and testbench

Sequences entry into and return from supervisor mode for the CPU core. It watches for interrupt, trap and return-from-interrupt requests at instruction boundaries, then drives the register bank select. Across multi-cycle sequences it saves the exception PC and cause, loads the trap vector and stalls fetch. It sits between the decode/fetch logic and the control register, and owns the `bank` signal that selects the user or supervisor control register copy.

---
 rtl/trap_pkg.sv | 25 ++
 rtl/trap_sequencer.sv | 123 ++++++++++++
 tb/tb_trap_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer.
// States, cause codes and control register bit positions.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SAVE,
    ST_SWITCH,
    ST_VECTOR,
    ST_RET_PC,
    ST_RET_BANK,
    ST_HALT
  } trap_state_t;

  localparam logic [2:0] CAUSE_SYSCALL = 3'd0;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd1;
  localparam logic [2:0] CAUSE_PFAULT  = 3'd2;
  localparam logic [2:0] CAUSE_IRQ     = 3'd4;

  localparam int CR_MODE   = 0;
  localparam int CR_CARRY  = 1;
  localparam int CR_PAGING = 2;
  localparam int CR_IRQEN  = 3;

endpackage

// File: rtl/trap_sequencer.sv
// Supervisor entry/return sequencer.
// Owns the bank select, saves epc/cause, loads the trap vector.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] VEC_BASE = PC_W'(16'h0010),
  parameter int VEC_STRIDE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_boundary,
  input  logic [7:0]      cr_cur,
  input  logic            irq,
  input  logic            trap_req,
  input  logic [1:0]      trap_cause,
  input  logic            reti_req,
  input  logic [PC_W-1:0] pc_in,
  output logic            bank,
  output logic            stall,
  output logic            pc_we,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] epc_out,
  output logic [2:0]      cause_out,
  output logic            ack,
  output logic            halted
);

  localparam int SH = $clog2(VEC_STRIDE);

  trap_state_t     state;
  logic [PC_W-1:0] vec;
  logic            irq_take;
  logic            cr_unused;

  assign cr_unused = ^{cr_cur[7:4], cr_cur[2:0]};

  // Stride is a power of two, so the vector is a shift-add.
  assign vec = VEC_BASE + (PC_W'(cause_out) << SH);

  assign irq_take = irq & cr_cur[CR_IRQEN] & ~bank;

  // Sequencer; outputs are registered for the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      bank      <= 1'b1;
      stall     <= 1'b0;
      pc_we     <= 1'b0;
      pc_out    <= '0;
      ack       <= 1'b0;
      halted    <= 1'b0;
      epc_out   <= '0;
      cause_out <= '0;
    end else begin
      pc_we  <= 1'b0;
      ack    <= 1'b0;
      pc_out <= '0;
      unique case (state)
        ST_RUN: begin
          if (fetch_boundary) begin
            if (trap_req) begin
              stall <= 1'b1;
              if (bank) begin
                state  <= ST_HALT;
                halted <= 1'b1;
              end else begin
                state     <= ST_SAVE;
                cause_out <= {1'b0, trap_cause};
              end
            end else if (reti_req) begin
              stall <= 1'b1;
              if (bank) begin
                state  <= ST_RET_PC;
                pc_we  <= 1'b1;
                pc_out <= epc_out;
              end else begin
                state     <= ST_SAVE;
                cause_out <= CAUSE_ILLEGAL;
              end
            end else if (irq_take) begin
              stall     <= 1'b1;
              state     <= ST_SAVE;
              cause_out <= CAUSE_IRQ;
            end
          end
        end
        ST_SAVE: begin
          epc_out <= pc_in;
          bank    <= 1'b1;
          state   <= ST_SWITCH;
        end
        ST_SWITCH: begin
          pc_we  <= 1'b1;
          pc_out <= vec;
          ack    <= 1'b1;
          state  <= ST_VECTOR;
        end
        ST_VECTOR: begin
          stall <= 1'b0;
          state <= ST_RUN;
        end
        ST_RET_PC: begin
          bank  <= 1'b0;
          ack   <= 1'b1;
          state <= ST_RET_BANK;
        end
        ST_RET_BANK: begin
          stall <= 1'b0;
          state <= ST_RUN;
        end
        ST_HALT: begin
          stall  <= 1'b1;
          halted <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer.
// Expected outputs are hand-computed per cycle.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_boundary = 1'b0;
  logic [7:0]  cr_cur = 8'h00;
  logic        irq = 1'b0;
  logic        trap_req = 1'b0;
  logic [1:0]  trap_cause = 2'd0;
  logic        reti_req = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic        bank, stall, pc_we, ack, halted;
  logic [15:0] pc_out, epc_out;
  logic [2:0]  cause_out;

  int checks = 0;
  int failures = 0;

  trap_sequencer dut (
    .clk(clk), .reset(reset),
    .fetch_boundary(fetch_boundary),
    .cr_cur(cr_cur), .irq(irq),
    .trap_req(trap_req),
    .trap_cause(trap_cause),
    .reti_req(reti_req), .pc_in(pc_in),
    .bank(bank), .stall(stall),
    .pc_we(pc_we), .pc_out(pc_out),
    .epc_out(epc_out),
    .cause_out(cause_out),
    .ack(ack), .halted(halted)
  );

  always #5 clk = ~clk;

  // {bank,stall,pc_we,ack,halted,pc_out}
  function automatic logic [20:0] obs();
    return {bank, stall, pc_we, ack, halted, pc_out};
  endfunction

  task automatic boundary(input logic t, input logic [1:0] c,
                          input logic r, input logic i);
    @(negedge clk);
    trap_req = t; trap_cause = c;
    reti_req = r; irq = i;
    fetch_boundary = 1'b1;
    @(posedge clk); #1;
    trap_req = 0; reti_req = 0; irq = 0;
    fetch_boundary = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (obs() !== {5'b10000, 16'h0} ||
          epc_out !== 16'h0 || cause_out !== 3'd0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d got %h/%h/%h want %h/0/0",
                 k, obs(), epc_out, cause_out, {5'b10000, 16'h0});
      end
    end
  endtask

  task automatic test_double_fault();
    logic [20:0] e;
    e = {5'b11001, 16'h0};
    boundary(1, 2'd2, 0, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (obs() !== e || epc_out !== 16'h0) begin
        failures++;
        $display("FAIL double_fault cyc%0d got %h want %h",
                 k, obs(), e);
      end
      if (k == 2) boundary(0, 2'd0, 1, 0);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (obs() !== {5'b10000, 16'h0}) begin
      failures++;
      $display("FAIL halt_cleared got %h want %h",
               obs(), {5'b10000, 16'h0});
    end
  endtask

  task automatic test_return(input string nm, input logic [15:0] epc);
    logic [20:0] e [3];
    e[0] = {5'b11100, epc};
    e[1] = {5'b01010, 16'h0};
    e[2] = {5'b00000, 16'h0};
    boundary(0, 2'd0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (obs() !== e[k]) begin
        failures++;
        $display("FAIL %s cyc%0d got %h want %h", nm, k, obs(), e[k]);
      end
    end
  endtask

  task automatic test_entry(input string nm, input logic t,
                            input logic [1:0] c, input logic r,
                            input logic i, input logic [15:0] pc,
                            input logic [2:0] ecause,
                            input logic [15:0] evec);
    logic [20:0] e [4];
    e[0] = {5'b01000, 16'h0};
    e[1] = {5'b11000, 16'h0};
    e[2] = {5'b11110, evec};
    e[3] = {5'b10000, 16'h0};
    pc_in = pc;
    boundary(t, c, r, i);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (obs() !== e[k]) begin
        failures++;
        $display("FAIL %s cyc%0d got %h want %h", nm, k, obs(), e[k]);
      end
    end
    checks++;
    if (epc_out !== pc || cause_out !== ecause) begin
      failures++;
      $display("FAIL %s_saved got epc=%h cause=%0d want %h/%0d",
               nm, epc_out, cause_out, pc, ecause);
    end
  endtask

  task automatic test_irq_masked();
    cr_cur = 8'h00;
    boundary(0, 2'd0, 0, 1);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (obs() !== {5'b00000, 16'h0} || cause_out !== 3'd0) begin
        failures++;
        $display("FAIL irq_masked got %h cause=%0d want %h cause=0",
                 obs(), cause_out, {5'b00000, 16'h0});
      end
    end
  endtask

  task automatic test_reset_mid();
    pc_in = 16'h0abc;
    boundary(1, 2'd0, 0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== {5'b11000, 16'h0}) begin
      failures++;
      $display("FAIL in_switch got %h want %h",
               obs(), {5'b11000, 16'h0});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== {5'b10000, 16'h0} ||
        epc_out !== 16'h0 || cause_out !== 3'd0) begin
      failures++;
      $display("FAIL reset_async got %h/%h/%0d want %h/0/0",
               obs(), epc_out, cause_out, {5'b10000, 16'h0});
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== {5'b10000, 16'h0}) begin
      failures++;
      $display("FAIL after_release got %h want %h",
               obs(), {5'b10000, 16'h0});
    end
    test_return("ret_after_reset", 16'h0000);
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_double_fault();
    test_return("ret_boot", 16'h0000);
    test_entry("syscall", 1, 2'd0, 0, 0, 16'h0120, 3'd0, 16'h0010);
    test_return("ret_syscall", 16'h0120);
    test_irq_masked();
    cr_cur = 8'h08;
    test_entry("irq", 0, 2'd0, 0, 1, 16'h0200, 3'd4, 16'h0020);
    test_return("ret_irq", 16'h0200);
    test_entry("trap_irq", 1, 2'd2, 0, 1, 16'h0310, 3'd2, 16'h0018);
    test_return("ret_trap", 16'h0310);
    test_entry("reti_user", 0, 2'd0, 1, 0, 16'h0400, 3'd1, 16'h0014);
    test_return("ret_illegal", 16'h0400);
    test_entry("trap_rsvd", 1, 2'd3, 0, 0, 16'h0500, 3'd3, 16'h001c);
    test_return("ret_rsvd", 16'h0500);
    cr_cur = 8'h00;
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
